// File: rtl/gate_vector_sequencer.sv
// Stimulus/check stage for the buf/xnor/nand gate block.
// Walks the five gate inputs through all 32 combinations, holds each vector for
// SETTLE_CYCLES edges, then samples z1/z2/z3 against locally computed expectations.
// Optional build macro: STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module gate_vector_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       z1,
  input  logic       z2,
  input  logic       z3,
  output logic       x1,
  output logic       x2,
  output logic       y2,
  output logic       x3,
  output logic       y3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_count,
  output logic       fail_valid,
  output logic [4:0] first_fail_idx,
  output logic [4:0] vec_idx
);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [4:0] vec_idx_q, vec_idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] err_q, err_d;
  logic       fail_valid_q, fail_valid_d;
  logic [4:0] first_q, first_d;

  logic e1, e2, e3;
  logic mismatch;
  logic last_vec;
  logic stop_now;

  // Expectations come from the vector currently on the outputs.
  assign e1       = vec_idx_q[4];
  assign e2       = ~(vec_idx_q[3] ^ vec_idx_q[2]);
  assign e3       = ~(vec_idx_q[1] & vec_idx_q[0]);
  assign mismatch = (z1 != e1) | (z2 != e2) | (z3 != e3);
  assign last_vec = (vec_idx_q == 5'd31);

`ifdef STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: if (start) state_d = StSettle;
      StSettle:       if (cnt_q == 4'd0) state_d = StCheck;
      StCheck:        state_d = (last_vec || stop_now) ? StDone : StSettle;
      default:        state_d = StIdle;
    endcase
  end

  // Datapath next-state: vector index, settle counter and result bookkeeping
  always_comb begin
    vec_idx_d    = vec_idx_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    first_d      = first_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          vec_idx_d    = 5'd0;
          cnt_d        = SettleLoad;
          err_d        = 6'd0;
          fail_valid_d = 1'b0;
          first_d      = 5'd0;
        end
      end
      StSettle: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end
      StCheck: begin
        if (mismatch) begin
          err_d = err_q + 6'd1;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            first_d      = vec_idx_q;
          end
        end
        // Index holds on the final or stopping vector so outputs keep showing it.
        if (!last_vec && !stop_now) begin
          vec_idx_d = vec_idx_q + 5'd1;
          cnt_d     = SettleLoad;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_idx_q    <= 5'd0;
      cnt_q        <= 4'd0;
      err_q        <= 6'd0;
      fail_valid_q <= 1'b0;
      first_q      <= 5'd0;
    end else begin
      vec_idx_q    <= vec_idx_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      first_q      <= first_d;
    end
  end

  // Outputs: status decoded from state, gate drives straight from the index register
  always_comb begin
    busy           = (state_q == StSettle) || (state_q == StCheck);
    done           = (state_q == StDone);
    pass           = done && (err_q == 6'd0);
    err_count      = err_q;
    fail_valid     = fail_valid_q;
    first_fail_idx = first_q;
    vec_idx        = vec_idx_q;
    x1             = vec_idx_q[4];
    x2             = vec_idx_q[3];
    y2             = vec_idx_q[2];
    x3             = vec_idx_q[1];
    y3             = vec_idx_q[0];
  end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Bench for gate_vector_sequencer: a gate-block model with selectable faults feeds
// the DUT; expected run results are queued at start and checked when done rises.
module tb_gate_vector_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;

  logic       z1, z2, z3;
  logic       x1, x2, y2, x3, y3;
  logic       busy, done, pass, fail_valid;
  logic [5:0] err_count;
  logic [4:0] first_fail_idx, vec_idx;

  logic       z1b, z2b, z3b;
  logic       x1b, x2b, y2b, x3b, y3b;
  logic       busy1, done1, pass1, fail_valid1;
  logic [5:0] err_count1;
  logic [4:0] first_fail_idx1, vec_idx1;

  // 0 ideal, 1 z3 stuck-0, 2 z1 stuck-0, 3 z2 inverted
  int fault_mode = 0;

  always #5 clk = ~clk;

  assign z1 = (fault_mode == 2) ? 1'b0 : x1;
  assign z2 = (fault_mode == 3) ? (x2 ^ y2) : ~(x2 ^ y2);
  assign z3 = (fault_mode == 1) ? 1'b0 : ~(x3 & y3);

  assign z1b = x1b;
  assign z2b = ~(x2b ^ y2b);
  assign z3b = ~(x3b & y3b);

  gate_vector_sequencer #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .z1(z1), .z2(z2), .z3(z3),
    .x1(x1), .x2(x2), .y2(y2), .x3(x3), .y3(y3), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid), .first_fail_idx(first_fail_idx),
    .vec_idx(vec_idx)
  );

  gate_vector_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .z1(z1b), .z2(z2b), .z3(z3b),
    .x1(x1b), .x2(x2b), .y2(y2b), .x3(x3b), .y3(y3b), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err_count1), .fail_valid(fail_valid1),
    .first_fail_idx(first_fail_idx1), .vec_idx(vec_idx1)
  );

  typedef struct {
    int err;
    int first;
    int fv;
    int vec;
    int lat;
    int pass_v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edges = 0;
  int   start_edge = 0;
  int   x1_toggles = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) edges++;
  always @(x1) x1_toggles++;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: on every rising done, pop the queued expectation and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("latency", edges - start_edge, e.lat);
          check("err_count", int'(err_count), e.err);
          check("first_fail_idx", int'(first_fail_idx), e.first);
          check("fail_valid", int'(fail_valid), e.fv);
          check("vec_idx", int'(vec_idx), e.vec);
          check("xy_outputs", int'({x1, x2, y2, x3, y3}), e.vec);
          check("pass", int'(pass), e.pass_v);
          check("busy_in_done", int'(busy), 0);
        end
      end
      done_prev = done;
    end
  end

  // rec=1 marks this pulse as the accepting one for latency measurement
  task automatic pulse_start(input bit rec);
    @(negedge clk);
    start = 1'b1;
    if (rec) start_edge = edges + 1;
    @(negedge clk);
    start = 1'b0;
    x1_toggles = 0;
  endtask

  task automatic wait_done(input int limit);
    for (int k = 0; k < limit; k++) begin
      @(posedge clk);
      #2;
      if (done) break;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic run_check(input int mode, input exp_t e);
    fault_mode = mode;
    sb.push_back(e);
    pulse_start(1'b1);
    check("busy_after_start", int'(busy), 1);
    check("done_cleared", int'(done), 0);
    check("pass_low_running", int'(pass), 0);
    wait_done(200);
  endtask

  task automatic wait_vec(input int idx);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (int'(vec_idx) == idx) break;
    end
    check("reach_vec", int'(vec_idx), idx);
  endtask

  initial begin
    exp_t e;
    int   n;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_xy", int'({x1, x2, y2, x3, y3}), 0);
    check("rst_vec_idx", int'(vec_idx), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err", int'(err_count), 0);
    check("rst_fail_valid", int'(fail_valid), 0);
    check("rst_first_fail", int'(first_fail_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ideal gate block
    e = '{err: 0, first: 0, fv: 0, vec: 31, lat: 96, pass_v: 1};
    run_check(0, e);

    // z3 stuck at 0: nand expected 0 only when x3=y3=1, so 24 of 32 fail
    e = '{err: 24, first: 0, fv: 1, vec: 31, lat: 96, pass_v: 0};
    run_check(1, e);

    // z1 stuck at 0: the 16 vectors with x1=1 fail, first is 16
    e = '{err: 16, first: 16, fv: 1, vec: 31, lat: 96, pass_v: 0};
    run_check(2, e);
    check("x1_toggles", x1_toggles, 1);

    // z2 inverted: every vector fails
`ifdef STOP_ON_FAIL_EN
    e = '{err: 1, first: 0, fv: 1, vec: 0, lat: 3, pass_v: 0};
`else
    e = '{err: 32, first: 0, fv: 1, vec: 31, lat: 96, pass_v: 0};
`endif
    run_check(3, e);

    // Start pulsed mid-run must not restart the sequence
    fault_mode = 0;
    e = '{err: 0, first: 0, fv: 0, vec: 31, lat: 96, pass_v: 1};
    sb.push_back(e);
    pulse_start(1'b1);
    wait_vec(10);
    pulse_start(1'b0);
    check("no_restart", int'(vec_idx >= 5'd10), 1);
    check("busy_kept", int'(busy), 1);
    wait_done(200);

    // Asynchronous reset mid-run, with errors already accumulated
    fault_mode = 1;
    pulse_start(1'b0);
    wait_vec(12);
    #2 rst_n = 1'b0;
    #1;
    check("arst_xy", int'({x1, x2, y2, x3, y3}), 0);
    check("arst_vec_idx", int'(vec_idx), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_err", int'(err_count), 0);
    check("arst_fail_valid", int'(fail_valid), 0);
    check("arst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_arst", int'(busy), 0);
    e = '{err: 0, first: 0, fv: 0, vec: 31, lat: 96, pass_v: 1};
    run_check(0, e);

    // SETTLE_CYCLES=1 instance: 64 edges to done
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      n++;
      #2;
      if (done1) break;
    end
    check("s1_latency", n, 64);
    check("s1_done", int'(done1), 1);
    check("s1_err", int'(err_count1), 0);
    check("s1_pass", int'(pass1), 1);
    check("s1_vec_idx", int'(vec_idx1), 31);

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
